// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

  // Operation select. Bit 0 marks a signed op, bit 1 marks a divide.
  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  // Iteration counter width: enough to count 0..width-1.
  function automatic int cnt_width(input int width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/mdu_abs.sv
// Operand magnitude/sign extraction for signed or unsigned operations.
module mdu_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             is_signed,
  output logic [WIDTH-1:0] mag,
  output logic             neg
);

  // Negative only when treated as signed; -2^(WIDTH-1) maps to itself, which
  // is the correct unsigned magnitude.
  always_comb begin
    neg = is_signed & value[WIDTH-1];
    mag = neg ? -value : value;
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Handshake: start is sampled only while idle (busy = 0); busy stays high from
// the accepting edge until the result edge; done pulses for one cycle with
// hi/lo valid and a new start is accepted in that same cycle.
import mdu_pkg::*;

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] inA,
  input  logic [WIDTH-1:0] inB,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_e           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd_b;
  logic             is_div_r, neg_res, neg_rem;

  logic             in_signed, in_div, in_b_zero;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             sign_a, sign_b;

  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [WIDTH-1:0]   iter_hi, iter_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] prod_fix;

  assign in_signed = (op == OP_MULT) || (op == OP_DIV);
  assign in_div    = (op == OP_DIVU) || (op == OP_DIV);
  assign in_b_zero = (inB == '0);

  mdu_abs #(.WIDTH(WIDTH)) u_abs_a (
    .value    (inA),
    .is_signed(in_signed),
    .mag      (mag_a),
    .neg      (sign_a)
  );

  mdu_abs #(.WIDTH(WIDTH)) u_abs_b (
    .value    (inB),
    .is_signed(in_signed),
    .mag      (mag_b),
    .neg      (sign_b)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state: divide by zero skips the iterations entirely.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = (in_div && in_b_zero) ? S_FIX : S_CALC;
      S_CALC:  if (cnt == CNT_LAST) state_next = S_FIX;
      S_FIX:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // One shift-add or restoring-divide step on the internal {acc_hi, acc_lo}.
  always_comb begin
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : '0);
    div_shift = {acc_hi, acc_lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_b};
    if (is_div_r) begin
      if (!div_diff[WIDTH]) begin
        iter_hi = div_diff[WIDTH-1:0];
        iter_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        iter_hi = div_shift[WIDTH-1:0];
        iter_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the raw magnitude result; divide by zero keeps the raw
  // dividend (parked in acc_hi) and an all-ones quotient.
  always_comb begin
    prod_fix = neg_res ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    if (div_by_zero) begin
      fix_hi = acc_hi;
      fix_lo = '1;
    end else if (is_div_r) begin
      fix_hi = neg_rem ? -acc_hi : acc_hi;
      fix_lo = neg_res ? -acc_lo : acc_lo;
    end else begin
      fix_hi = prod_fix[2*WIDTH-1:WIDTH];
      fix_lo = prod_fix[WIDTH-1:0];
    end
  end

  // Datapath, handshake outputs and HI/LO registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      opnd_b      <= '0;
      is_div_r    <= 1'b0;
      neg_res     <= 1'b0;
      neg_rem     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt         <= '0;
            acc_hi      <= (in_div && in_b_zero) ? inA : '0;
            acc_lo      <= mag_a;
            opnd_b      <= mag_b;
            is_div_r    <= in_div;
            neg_res     <= sign_a ^ sign_b;
            neg_rem     <= sign_a;
            div_by_zero <= in_div && in_b_zero;
            busy        <= 1'b1;
          end else begin
            if (hi_wen) hi <= wd;
            if (lo_wen) lo <= wd;
          end
        end
        S_CALC: begin
          acc_hi <= iter_hi;
          acc_lo <= iter_lo;
          cnt    <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
        end
        S_FIX: begin
          hi   <= fix_hi;
          lo   <= fix_lo;
          busy <= 1'b0;
          done <= 1'b1;
        end
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit (WIDTH = 32).
import mdu_pkg::*;

module tb_mul_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] in_a = '0, in_b = '0, wd = '0;
  logic        hi_wen = 1'b0, lo_wen = 1'b0;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  mul_div_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .inA        (in_a),
    .inB        (in_b),
    .hi_wen     (hi_wen),
    .lo_wen     (lo_wen),
    .wd         (wd),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .hi         (hi),
    .lo         (lo)
  );

  // Clock: 10 time units; inputs driven and outputs sampled on negedge.
  always #5 clock = ~clock;

  // Reference result {hi, lo} computed with plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ua, ub;
    logic signed [63:0] sa, sb, q, r;
    ua = {32'h0, a};
    ub = {32'h0, b};
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (o)
      2'b00: return ua * ub;
      2'b01: return sa * sb;
      2'b10: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
    endcase
  endfunction

  // Wait (bounded) for done; report latency, busy cycles and hi/lo stability.
  task automatic wait_done(output int lat, output int busy_cnt, output bit hold_ok, output bit timed_out);
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    lat = 0; busy_cnt = 0; hold_ok = 1'b1; timed_out = 1'b0;
    while (done !== 1'b1) begin
      if (busy === 1'b1) busy_cnt++;
      if (hi !== h0 || lo !== l0) hold_ok = 1'b0;
      if (lat >= 100) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge clock);
      lat++;
    end
  endtask

  // Driver: present one start for a single edge, then wait for the result.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output bit hold_ok, output bit timed_out);
    start = 1'b1; op = o; in_a = a; in_b = b;
    @(negedge clock);
    start = 1'b0;
    wait_done(lat, busy_cnt, hold_ok, timed_out);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, div_by_zero});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin
      failures++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_release_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_multu;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc, hold, to);
    checks++;
    if (to) begin failures++; $display("FAIL multu_timeout got=timeout exp=done"); end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL multu_latency got=%0d exp=33", lat); end
    checks++;
    if (bc != 33) begin failures++; $display("FAIL multu_busy_cycles got=%0d exp=33", bc); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL multu_busy_with_done got=%b exp=0", busy); end
    checks++;
    if (!hold) begin failures++; $display("FAIL multu_hilo_hold got=changed exp=stable"); end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin failures++; $display("FAIL multu_result got=%h exp=%h", {hi, lo}, e); end
    @(negedge clock);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL multu_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_mult_divu;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFF1});
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, lat, bc, hold, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {hi, lo} !== e) begin failures++; $display("FAIL mult_result got=%h exp=%h", {hi, lo}, e); end
    exp_q.push_back({32'd2, 32'd14});
    run_op(OP_DIVU, 32'd100, 32'd7, lat, bc, hold, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {hi, lo} !== e) begin failures++; $display("FAIL divu_result got=%h exp=%h", {hi, lo}, e); end
    checks++;
    if (lat != 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", lat); end
  endtask

  task automatic test_div;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, bc, hold, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {hi, lo} !== e) begin failures++; $display("FAIL div_neg_result got=%h exp=%h", {hi, lo}, e); end
    exp_q.push_back({32'h0, 32'h8000_0000});
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, bc, hold, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {hi, lo} !== e) begin failures++; $display("FAIL div_overflow got=%h exp=%h", {hi, lo}, e); end
    checks++;
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL div_overflow_flag got=%b exp=0", div_by_zero); end
  endtask

  task automatic test_div_by_zero;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    exp_q.push_back({32'h0000_1234, 32'hFFFF_FFFF});
    run_op(OP_DIVU, 32'h0000_1234, 32'h0, lat, bc, hold, to);
    checks++;
    if (to || lat != 1) begin failures++; $display("FAIL dbz_latency got=%0d exp=1", lat); end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin failures++; $display("FAIL dbz_result got=%h exp=%h", {hi, lo}, e); end
    checks++;
    if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag got=%b exp=1", div_by_zero); end
    repeat (3) @(negedge clock);
    checks++;
    if (div_by_zero !== 1'b1) begin failures++; $display("FAIL dbz_flag_hold got=%b exp=1", div_by_zero); end
    exp_q.push_back({32'h0, 32'd6});
    start = 1'b1; op = OP_MULTU; in_a = 32'd2; in_b = 32'd3;
    @(negedge clock);
    start = 1'b0;
    checks++;
    if (div_by_zero !== 1'b0) begin failures++; $display("FAIL dbz_flag_clear got=%b exp=0", div_by_zero); end
    wait_done(lat, bc, hold, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {hi, lo} !== e) begin failures++; $display("FAIL dbz_next_result got=%h exp=%h", {hi, lo}, e); end
  endtask

  task automatic test_start_while_busy;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    logic [31:0] h_before;
    h_before = hi;
    exp_q.push_back({32'h0, 32'h000F_4240});
    start = 1'b1; op = OP_MULTU; in_a = 32'd1000; in_b = 32'd1000;
    @(negedge clock);
    start = 1'b0;
    repeat (5) @(negedge clock);
    start = 1'b1; op = OP_DIVU; in_a = 32'd9; in_b = 32'd3;
    hi_wen = 1'b1; wd = 32'hAA;
    @(negedge clock);
    start = 1'b0; hi_wen = 1'b0;
    checks++;
    if (hi !== h_before) begin failures++; $display("FAIL busy_mthi got=%h exp=%h", hi, h_before); end
    wait_done(lat, bc, hold, to);
    checks++;
    if (to || lat + 6 != 33) begin failures++; $display("FAIL busy_start_latency got=%0d exp=33", lat + 6); end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin failures++; $display("FAIL busy_start_result got=%h exp=%h", {hi, lo}, e); end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_start_pending got=%b exp=0", busy); end
  endtask

  task automatic test_mt_writes;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    logic [31:0] l_before;
    l_before = lo;
    hi_wen = 1'b1; wd = 32'hAA;
    @(negedge clock);
    hi_wen = 1'b0;
    checks++;
    if ({hi, lo} !== {32'hAA, l_before}) begin
      failures++; $display("FAIL mthi got=%h exp=%h", {hi, lo}, {32'hAA, l_before});
    end
    hi_wen = 1'b1; lo_wen = 1'b1; wd = 32'h1357;
    @(negedge clock);
    hi_wen = 1'b0; lo_wen = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h1357, 32'h1357}) begin
      failures++; $display("FAIL mthi_mtlo got=%h exp=%h", {hi, lo}, {32'h1357, 32'h1357});
    end
    exp_q.push_back({32'h0, 32'd42});
    start = 1'b1; op = OP_MULTU; in_a = 32'd6; in_b = 32'd7;
    lo_wen = 1'b1; wd = 32'h55;
    @(negedge clock);
    start = 1'b0; lo_wen = 1'b0;
    checks++;
    if (lo !== 32'h1357) begin failures++; $display("FAIL start_mtlo_drop got=%h exp=%h", lo, 32'h1357); end
    wait_done(lat, bc, hold, to);
    e = exp_q.pop_front();
    checks++;
    if (to || {hi, lo} !== e) begin failures++; $display("FAIL start_mtlo_result got=%h exp=%h", {hi, lo}, e); end
  endtask

  task automatic test_back_to_back;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    logic [1:0]  ops[3] = '{OP_MULT, OP_DIV, OP_DIVU};
    logic [31:0] as[3]  = '{32'hFFFF_0000, 32'd1000, 32'hDEAD_BEEF};
    logic [31:0] bs[3]  = '{32'h0001_2345, 32'hFFFF_FFF3, 32'd77};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(model(ops[i], as[i], bs[i]));
      run_op(ops[i], as[i], bs[i], lat, bc, hold, to);
      checks++;
      if (to || lat != 33) begin failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=33", i, lat); end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e) begin failures++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, {hi, lo}, e); end
    end
  endtask

  task automatic test_reset_mid_op;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    start = 1'b1; op = OP_MULTU; in_a = 32'hFFFF; in_b = 32'hFFFF;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      failures++; $display("FAIL midreset_flags got=%b exp=000", {busy, done, div_by_zero});
    end
    checks++;
    if ({hi, lo} !== 64'h0) begin failures++; $display("FAIL midreset_hilo got=%h exp=0", {hi, lo}); end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL midreset_idle got=%b exp=0", busy); end
    exp_q.push_back({32'h0, 32'd42});
    run_op(OP_MULTU, 32'd6, 32'd7, lat, bc, hold, to);
    checks++;
    if (to || lat != 33) begin failures++; $display("FAIL midreset_latency got=%0d exp=33", lat); end
    e = exp_q.pop_front();
    checks++;
    if ({hi, lo} !== e) begin failures++; $display("FAIL midreset_result got=%h exp=%h", {hi, lo}, e); end
  endtask

  task automatic test_random;
    int lat, bc; bit hold, to;
    logic [63:0] e;
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'h0;
        1, 2:    b = 32'($urandom_range(1, 20));
        3:       b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      exp_q.push_back(model(o, a, b));
      run_op(o, a, b, lat, bc, hold, to);
      checks++;
      if (to || lat != ((o[1] && b == 0) ? 1 : 33)) begin
        failures++; $display("FAIL rand_latency[%0d] op=%0d got=%0d", i, o, lat);
      end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e) begin
        failures++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, {hi, lo}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_multu();
    test_mult_divu();
    test_div();
    test_div_by_zero();
    test_start_while_busy();
    test_mt_writes();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
